amp_i2c_cfg_seq: RTL and testbench

AMP_I2C_CFG_SEQ -- requirements
Module: amp_i2c_cfg_seq

---
 rtl/amp_i2c_cfg_seq.sv | 213 +++++++++++++++++++++
 tb/tb_amp_i2c_cfg_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/amp_i2c_cfg_seq.sv
// amp_i2c_cfg_seq -- I2C master that writes a register table into an amplifier.
//
// On start, every table entry is sent as one I2C write transaction:
//   START, {DEV_ADDR,W}, ACK, reg addr, ACK, data, ACK, STOP.
// If any byte is NACKed, the entry is retried up to MAX_RETRY times.
// When retries run out, the sequence stops with err set.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   start           single-cycle request; ignored while busy
//   tbl_idx         index of the current table entry
//   tbl_data        combinational table read: [15:8] register address, [7:0] data
//   scl_oe, sda_oe  1 = pull the line low, 0 = release it
//   scl_in, sda_in  synchronised bus levels
//   busy            sequence in progress
//   done            all entries acknowledged
//   err             retries exhausted
//   err_idx         entry that failed
module amp_i2c_cfg_seq #(
   parameter int unsigned CLK_DIV   = 4,
   parameter logic [6:0]  DEV_ADDR  = 7'h20,
   parameter int unsigned NUM_REGS  = 2,
   parameter int unsigned MAX_RETRY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [3:0]  tbl_idx,
   input  logic [15:0] tbl_data,
   output logic        scl_oe,
   output logic        sda_oe,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [3:0]  err_idx
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_REG, S_DATA, S_STOP, S_NEXT, S_FINISH
   } state_t;

   localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [3:0] IDX_LAST  = 4'(NUM_REGS - 1);
   localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

   state_t     state_q, state_d;
   logic [7:0] div_q, div_d;       // clk count within a quarter
   logic [1:0] qtr_q, qtr_d;       // quarter within a bit / START / STOP
   logic [3:0] bit_q, bit_d;       // 0..7 data bits, 8 = ACK slot
   logic [7:0] sr_q, sr_d;         // outgoing byte, MSB on the wire
   logic       nack_q, nack_d;
   logic [2:0] retry_q, retry_d;
   logic [3:0] idx_q, idx_d;
   logic [3:0] eidx_q, eidx_d;
   logic       done_q, done_d;
   logic       err_q, err_d;

   logic in_byte, timed, hold, tick;

   assign in_byte = (state_q == S_ADDR) || (state_q == S_REG) || (state_q == S_DATA);
   assign timed   = in_byte || (state_q == S_START) || (state_q == S_STOP);
   // Clock stretching: SCL is released in Q1 but a slave may still hold it low.
   assign hold    = (qtr_q == 2'd1) && !scl_in && (in_byte || (state_q == S_STOP));
   assign tick    = timed && !hold && (div_q == DIV_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         qtr_q   <= '0;
         bit_q   <= '0;
         sr_q    <= '0;
         nack_q  <= 1'b0;
         retry_q <= '0;
         idx_q   <= '0;
         eidx_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         qtr_q   <= qtr_d;
         bit_q   <= bit_d;
         sr_q    <= sr_d;
         nack_q  <= nack_d;
         retry_q <= retry_d;
         idx_q   <= idx_d;
         eidx_q  <= eidx_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      qtr_d   = qtr_q;
      bit_d   = bit_q;
      sr_d    = sr_q;
      nack_d  = nack_q;
      retry_d = retry_q;
      idx_d   = idx_q;
      eidx_d  = eidx_q;
      done_d  = done_q;
      err_d   = err_q;
      scl_oe  = 1'b0;
      sda_oe  = 1'b0;

      if (timed && !hold)
         div_d = tick ? 8'd0 : div_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_START;
               div_d   = '0;
               qtr_d   = '0;
               nack_d  = 1'b0;
               retry_d = '0;
               idx_d   = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_START: begin
            // quarter 0: bus idle, quarter 1: SDA falls while SCL is high
            sda_oe = (qtr_q == 2'd1);
            if (tick) begin
               if (qtr_q == 2'd1) begin
                  state_d = S_ADDR;
                  qtr_d   = '0;
                  bit_d   = '0;
                  sr_d    = {DEV_ADDR, 1'b0};
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         S_ADDR, S_REG, S_DATA: begin
            scl_oe = (qtr_q == 2'd0) || (qtr_q == 2'd3);
            sda_oe = (bit_q != 4'd8) && !sr_q[7];
            if (tick) begin
               if ((qtr_q == 2'd2) && (bit_q == 4'd8) && sda_in)
                  nack_d = 1'b1;
               if (qtr_q == 2'd3) begin
                  qtr_d = '0;
                  if (bit_q == 4'd8) begin
                     bit_d = '0;
                     // the next byte is latched here, at the start of its first Q0
                     if (nack_q)                  state_d = S_STOP;
                     else if (state_q == S_ADDR) begin
                        state_d = S_REG;
                        sr_d    = tbl_data[15:8];
                     end else if (state_q == S_REG) begin
                        state_d = S_DATA;
                        sr_d    = tbl_data[7:0];
                     end else                     state_d = S_STOP;
                  end else begin
                     bit_d = bit_q + 4'd1;
                     sr_d  = {sr_q[6:0], 1'b0};
                  end
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         S_STOP: begin
            // SCL rises with SDA low, then SDA rises: the bus is free afterwards
            scl_oe = (qtr_q == 2'd0);
            sda_oe = (qtr_q != 2'd2);
            if (tick) begin
               if (qtr_q == 2'd2) begin
                  state_d = S_NEXT;
                  qtr_d   = '0;
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end
         end
         S_NEXT: begin
            if (nack_q) begin
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 3'd1;
                  nack_d  = 1'b0;
                  state_d = S_START;
               end else begin
                  err_d   = 1'b1;
                  eidx_d  = idx_q;
                  state_d = S_FINISH;
               end
            end else if (idx_q == IDX_LAST) begin
               done_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 4'd1;
               retry_d = '0;
               state_d = S_START;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   assign busy    = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign tbl_idx = idx_q;
   assign err_idx = eidx_q;
   assign done    = done_q;
   assign err     = err_q;

endmodule

// File: tb/tb_amp_i2c_cfg_seq.sv
// Directed bench for amp_i2c_cfg_seq. A small behavioural I2C slave decodes
// the bus, captures bytes, drives ACK/NACK and optionally stretches SCL.
module tb_amp_i2c_cfg_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  tbl_idx, err_idx;
   logic [15:0] tbl_data;
   logic        scl_oe, sda_oe, scl_in, sda_in, busy, done, err;

   always #5 clk = ~clk;

   amp_i2c_cfg_seq #(.CLK_DIV(2), .DEV_ADDR(7'h20), .NUM_REGS(2), .MAX_RETRY(2)) dut (
      .clk(clk), .reset(reset), .start(start), .tbl_idx(tbl_idx), .tbl_data(tbl_data),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in),
      .busy(busy), .done(done), .err(err), .err_idx(err_idx)
   );

   assign tbl_data = (tbl_idx == 4'd0) ? 16'h4018 : 16'h3508;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // ---------------- slave model ----------------
   logic       stretch = 1'b0, ack_drv = 1'b0;
   logic       slv_rst = 1'b1;
   logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_oe = 1'b0;
   logic       scl_l, sda_l, nack_now;
   logic [7:0] cur = '0;
   logic [7:0] cap[$];
   logic [7:0] exp_b[$];
   int         bitn = 0, byten = 0, n_start = 0, n_stop = 0, stretch_cnt = 0;
   int         nack_mode = 0;   // 0 ack all, 1 nack first data byte once, 2 nack address always
   bit         nack_used = 0, stretch_arm = 0;

   assign scl_in = !scl_oe && !stretch;
   assign sda_in = !sda_oe && !ack_drv;

   always @(negedge clk) begin
      if (slv_rst) begin
         stretch = 1'b0; ack_drv = 1'b0; bitn = 0; byten = 0;
         prev_scl = 1'b1; prev_sda = 1'b1; prev_oe = 1'b0;
      end else begin
         if (stretch_arm && byten == 1 && bitn == 3 && !scl_oe && prev_oe && !stretch) begin
            stretch = 1'b1; stretch_cnt = 10; stretch_arm = 0;
         end else if (stretch) begin
            stretch_cnt--;
            if (stretch_cnt == 0) stretch = 1'b0;
         end
         scl_l = !scl_oe && !stretch;
         sda_l = !sda_oe && !ack_drv;
         if (prev_scl && scl_l && prev_sda && !sda_l) begin
            n_start++; bitn = 0; byten = 0;
         end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
            n_stop++;
         end else if (!prev_scl && scl_l) begin
            if (bitn < 8) begin
               cur = {cur[6:0], sda_l};
               bitn++;
               if (bitn == 8) cap.push_back(cur);
            end else begin
               bitn = 9;
            end
         end else if (prev_scl && !scl_l) begin
            if (bitn == 8) begin
               nack_now = (nack_mode == 2 && byten == 0) ||
                          (nack_mode == 1 && byten == 2 && !nack_used);
               if (nack_now && nack_mode == 1) nack_used = 1;
               ack_drv = !nack_now;
            end else if (bitn == 9) begin
               ack_drv = 1'b0; bitn = 0; byten++;
            end
         end
         prev_scl = scl_l; prev_sda = sda_l; prev_oe = scl_oe;
      end
   end

   // ---------------- helpers ----------------
   task automatic slv_clear();
      cap.delete(); n_start = 0; n_stop = 0; nack_used = 0;
   endtask

   task automatic chk_bytes(input string tag);
      chk({tag, "_nbytes"}, cap.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < cap.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), cap[i], exp_b[i]);
   endtask

   // cyc = clk edges from the edge that accepts start until done/err is seen
   task automatic run(input int pulse_at, output int cyc);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (!(done || err) && cyc < 5000) begin
         @(posedge clk); #1; cyc++;
         start = (cyc == pulse_at);
      end
      start = 1'b0;
      chk("finish_in_time", 32'(done || err), 1);
   endtask

   int cyc, guard;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl_oe", scl_oe, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_tbl_idx", tbl_idx, 0);
      chk("rst_err_idx", err_idx, 0);
      reset = 1'b1; slv_rst = 1'b0;
      repeat (4) @(posedge clk);

      // normal run
      slv_clear(); exp_b = '{8'h40, 8'h40, 8'h18, 8'h40, 8'h35, 8'h08};
      run(-1, cyc);
      chk("norm_cycles", cyc, 454);
      chk("norm_done", done, 1);
      chk("norm_err", err, 0);
      #20;
      chk("norm_busy_after", busy, 0);
      chk("norm_starts", n_start, 2);
      chk("norm_stops", n_stop, 2);
      chk_bytes("norm");

      // start pulsed while busy has no effect
      slv_clear();
      run(100, cyc);
      chk("busy_start_cycles", cyc, 454);
      chk("busy_start_done", done, 1);
      chk("busy_start_starts", n_start, 2);
      chk_bytes("busy_start");
      #20;

      // one NACK on the first data byte: entry 0 repeated, then entry 1
      slv_clear(); nack_mode = 1;
      exp_b = '{8'h40, 8'h40, 8'h18, 8'h40, 8'h40, 8'h18, 8'h40, 8'h35, 8'h08};
      run(-1, cyc);
      chk("nack1_cycles", cyc, 681);
      chk("nack1_done", done, 1);
      chk("nack1_err", err, 0);
      chk("nack1_starts", n_start, 3);
      chk_bytes("nack1");
      #20;

      // address always NACKed: three attempts then err
      slv_clear(); nack_mode = 2;
      exp_b = '{8'h40, 8'h40, 8'h40};
      run(-1, cyc);
      chk("nackall_cycles", cyc, 249);
      chk("nackall_err", err, 1);
      chk("nackall_done", done, 0);
      chk("nackall_err_idx", err_idx, 0);
      #20;
      chk("nackall_scl_oe", scl_oe, 0);
      chk("nackall_sda_oe", sda_oe, 0);
      chk("nackall_busy", busy, 0);
      chk("nackall_starts", n_start, 3);
      chk("nackall_stops", n_stop, 3);
      chk_bytes("nackall");

      // clock stretch of 10 cycles in REG byte bit 3 of entry 0
      slv_clear(); nack_mode = 0; stretch_arm = 1;
      exp_b = '{8'h40, 8'h40, 8'h18, 8'h40, 8'h35, 8'h08};
      run(-1, cyc);
      chk("stretch_cycles", cyc, 464);
      chk("stretch_done", done, 1);
      chk_bytes("stretch");
      #20;

      // reset in the middle of entry 1's DATA byte
      slv_clear();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      guard = 0;
      while (!(cap.size() == 5 && tbl_idx == 4'd1) && guard < 2000) begin
         @(negedge clk); guard++;
      end
      chk("rst_mid_reached", 32'(cap.size() == 5 && tbl_idx == 4'd1), 1);
      repeat (20) @(negedge clk);
      chk("rst_mid_busy_before", busy, 1);
      reset = 1'b0; slv_rst = 1'b1;
      #1;
      chk("rst_mid_scl_oe", scl_oe, 0);
      chk("rst_mid_sda_oe", sda_oe, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_tbl_idx", tbl_idx, 0);
      @(posedge clk); #1;
      chk("rst_mid_busy_edge", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1; slv_rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_mid_idle", busy, 0);
      slv_clear();
      run(-1, cyc);
      chk("rst_rerun_cycles", cyc, 454);
      chk("rst_rerun_done", done, 1);
      chk_bytes("rst_rerun");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
